// File: rtl/csr_axi_bridge.sv
// AXI subordinate front end for the FIFO CSR register file.
// Converts AW/W/B and AR/R channel traffic into single-cycle register write
// and read strobes on csr_clk. Write bursts are incrementing, terminated by
// wlast, and wrap the address at 2^ADDR_WIDTH. Reads are single beat.
// Optional feature macro: CSR_ADDR_CHECK_EN -- when defined, addresses at or
// above NUM_REGS are not forwarded and are answered with SLVERR.
module csr_axi_bridge #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned NUM_REGS   = 2
) (
  input  logic                  csr_clk,
  input  logic                  csr_resetn,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  input  logic                  s_axi_wlast,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  output logic [1:0]            s_axi_bresp,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic                  s_axi_rlast,
  output logic [1:0]            s_axi_rresp,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  csr_write_enable,
  output logic [ADDR_WIDTH-1:0] r_addr,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  csr_read_enable
);

`ifdef CSR_ADDR_CHECK_EN
  localparam bit ADDR_CHECK = 1'b1;
`else
  localparam bit ADDR_CHECK = 1'b0;
`endif

  localparam int unsigned CNT_W = 3;
  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(RD_LATENCY - 1);
  localparam logic [ADDR_WIDTH:0] REG_LIMIT = (ADDR_WIDTH + 1)'(NUM_REGS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;

  // Address is rejected only when range checking is built in
  function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] addr);
    return ADDR_CHECK && ({1'b0, addr} >= REG_LIMIT);
  endfunction

  w_state_t              w_state, w_state_d;
  logic [ADDR_WIDTH-1:0] cur_addr, cur_addr_d;
  logic                  werr, werr_d;
  logic                  awready_d, wready_d, bvalid_d, we_d;
  logic [1:0]            bresp_d;
  logic [ADDR_WIDTH-1:0] w_addr_d;
  logic [DATA_WIDTH-1:0] wdata_d;

  r_state_t              r_state, r_state_d;
  logic [CNT_W-1:0]      lat_cnt, lat_cnt_d;
  logic                  rerr, rerr_d;
  logic                  arready_d, rvalid_d, rlast_d, re_d;
  logic [1:0]            rresp_d;
  logic [ADDR_WIDTH-1:0] r_addr_d;
  logic [DATA_WIDTH-1:0] rdata_q_d;

  // Write FSM next state and next registered outputs
  always_comb begin
    w_state_d  = w_state;
    cur_addr_d = cur_addr;
    werr_d     = werr;
    awready_d  = s_axi_awready;
    wready_d   = s_axi_wready;
    bvalid_d   = s_axi_bvalid;
    bresp_d    = s_axi_bresp;
    w_addr_d   = w_addr;
    wdata_d    = wdata;
    we_d       = 1'b0;
    case (w_state)
      W_IDLE: begin
        awready_d = 1'b1;
        if (s_axi_awvalid && s_axi_awready) begin
          cur_addr_d = s_axi_awaddr;
          werr_d     = 1'b0;
          awready_d  = 1'b0;
          wready_d   = 1'b1;
          w_state_d  = W_DATA;
        end
      end
      W_DATA: begin
        if (s_axi_wvalid && s_axi_wready) begin
          w_addr_d   = cur_addr;
          wdata_d    = s_axi_wdata;
          we_d       = !out_of_range(cur_addr);
          werr_d     = werr || out_of_range(cur_addr);
          cur_addr_d = cur_addr + ADDR_WIDTH'(1);
          if (s_axi_wlast) begin
            wready_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = (werr || out_of_range(cur_addr)) ? RESP_SLVERR : RESP_OKAY;
            w_state_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (s_axi_bready) begin
          bvalid_d  = 1'b0;
          bresp_d   = RESP_OKAY;
          awready_d = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: begin
        awready_d = 1'b0;
        wready_d  = 1'b0;
        bvalid_d  = 1'b0;
        bresp_d   = RESP_OKAY;
        w_state_d = W_IDLE;
      end
    endcase
  end

  // Write FSM state and output registers
  always_ff @(posedge csr_clk or negedge csr_resetn) begin
    if (!csr_resetn) begin
      w_state          <= W_IDLE;
      cur_addr         <= '0;
      werr             <= 1'b0;
      s_axi_awready    <= 1'b0;
      s_axi_wready     <= 1'b0;
      s_axi_bvalid     <= 1'b0;
      s_axi_bresp      <= '0;
      w_addr           <= '0;
      wdata            <= '0;
      csr_write_enable <= 1'b0;
    end else begin
      w_state          <= w_state_d;
      cur_addr         <= cur_addr_d;
      werr             <= werr_d;
      s_axi_awready    <= awready_d;
      s_axi_wready     <= wready_d;
      s_axi_bvalid     <= bvalid_d;
      s_axi_bresp      <= bresp_d;
      w_addr           <= w_addr_d;
      wdata            <= wdata_d;
      csr_write_enable <= we_d;
    end
  end

  // Read FSM next state and next registered outputs
  always_comb begin
    r_state_d = r_state;
    lat_cnt_d = lat_cnt;
    rerr_d    = rerr;
    arready_d = s_axi_arready;
    rvalid_d  = s_axi_rvalid;
    rlast_d   = s_axi_rlast;
    rresp_d   = s_axi_rresp;
    rdata_q_d = s_axi_rdata;
    r_addr_d  = r_addr;
    re_d      = 1'b0;
    case (r_state)
      R_IDLE: begin
        arready_d = 1'b1;
        if (s_axi_arvalid && s_axi_arready) begin
          arready_d = 1'b0;
          r_addr_d  = s_axi_araddr;
          rerr_d    = out_of_range(s_axi_araddr);
          re_d      = !out_of_range(s_axi_araddr);
          lat_cnt_d = '0;
          r_state_d = R_WAIT;
        end
      end
      R_WAIT: begin
        if (lat_cnt == LAT_LAST) begin
          rdata_q_d = rerr ? '0 : rdata;
          rvalid_d  = 1'b1;
          rlast_d   = 1'b1;
          rresp_d   = rerr ? RESP_SLVERR : RESP_OKAY;
          r_state_d = R_DATA;
        end else begin
          lat_cnt_d = lat_cnt + CNT_W'(1);
        end
      end
      R_DATA: begin
        if (s_axi_rready) begin
          rvalid_d  = 1'b0;
          rlast_d   = 1'b0;
          rresp_d   = RESP_OKAY;
          arready_d = 1'b1;
          r_state_d = R_IDLE;
        end
      end
      default: begin
        arready_d = 1'b0;
        rvalid_d  = 1'b0;
        rlast_d   = 1'b0;
        rresp_d   = RESP_OKAY;
        r_state_d = R_IDLE;
      end
    endcase
  end

  // Read FSM state and output registers
  always_ff @(posedge csr_clk or negedge csr_resetn) begin
    if (!csr_resetn) begin
      r_state         <= R_IDLE;
      lat_cnt         <= '0;
      rerr            <= 1'b0;
      s_axi_arready   <= 1'b0;
      s_axi_rvalid    <= 1'b0;
      s_axi_rlast     <= 1'b0;
      s_axi_rresp     <= '0;
      s_axi_rdata     <= '0;
      r_addr          <= '0;
      csr_read_enable <= 1'b0;
    end else begin
      r_state         <= r_state_d;
      lat_cnt         <= lat_cnt_d;
      rerr            <= rerr_d;
      s_axi_arready   <= arready_d;
      s_axi_rvalid    <= rvalid_d;
      s_axi_rlast     <= rlast_d;
      s_axi_rresp     <= rresp_d;
      s_axi_rdata     <= rdata_q_d;
      r_addr          <= r_addr_d;
      csr_read_enable <= re_d;
    end
  end

endmodule
